// File: rtl/fpu_misc_pipe_pkg.sv
// Shared types for the FP misc pipe: operation select, exception flag layout
// and the recoded canonical NaN used by FMIN/FMAX.
`ifndef FPU_RECODED_CANONICAL_NAN
`define FPU_RECODED_CANONICAL_NAN 33'h0_E040_0000
`endif

package fpu_misc_pipe_pkg;

   typedef enum logic [2:0] {
      eFMIN   = 3'd0,
      eFMAX   = 3'd1,
      eFSGNJ  = 3'd2,
      eFSGNJN = 3'd3,
      eFSGNJX = 3'd4
   } fpu_misc_op_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fpu_fflags_s;

endpackage

// File: rtl/fpu_misc_pipe_fmin_fmax.sv
// Combinational RISC-V FMIN/FMAX on recoded operands (-0 < +0, NaN handling,
// NV on any signalling NaN input).
module fpu_misc_pipe_fmin_fmax #(
   parameter  int exp_width_p = 8,
   parameter  int sig_width_p = 24,
   localparam int rd_lp       = exp_width_p + sig_width_p + 1
) (
   input  logic [rd_lp-1:0] a_i,
   input  logic [rd_lp-1:0] b_i,
   input  logic             max_i,
   output logic [rd_lp-1:0] result_o,
   output logic             nv_o
);

   localparam logic [rd_lp-1:0] canonical_nan_lp = rd_lp'(`FPU_RECODED_CANONICAL_NAN);

   function automatic logic is_nan(input logic [rd_lp-1:0] x);
      return &x[rd_lp-2 -: 3];
   endfunction

   function automatic logic is_snan(input logic [rd_lp-1:0] x);
      return is_nan(x) & ~x[sig_width_p-2];
   endfunction

   function automatic logic is_zero(input logic [rd_lp-1:0] x);
      return ~|x[rd_lp-2 -: 3];
   endfunction

   logic             a_nan_s;
   logic             b_nan_s;
   logic             a_lt_b_s;
   logic [rd_lp-2:0] a_mag_s;
   logic [rd_lp-2:0] b_mag_s;

   // Order the operands by sign and recoded magnitude, then pick per NaN rules
   always_comb begin
      a_nan_s = is_nan(a_i);
      b_nan_s = is_nan(b_i);
      // zeros may carry junk below the exponent class bits, so flatten them
      a_mag_s = is_zero(a_i) ? '0 : a_i[rd_lp-2:0];
      b_mag_s = is_zero(b_i) ? '0 : b_i[rd_lp-2:0];
      if (a_i[rd_lp-1] != b_i[rd_lp-1]) begin
         a_lt_b_s = a_i[rd_lp-1];
      end else if (a_i[rd_lp-1]) begin
         a_lt_b_s = (a_mag_s > b_mag_s);
      end else begin
         a_lt_b_s = (a_mag_s < b_mag_s);
      end
      nv_o = is_snan(a_i) | is_snan(b_i);
      if (a_nan_s & b_nan_s) begin
         result_o = canonical_nan_lp;
      end else if (a_nan_s) begin
         result_o = b_i;
      end else if (b_nan_s) begin
         result_o = a_i;
      end else if (a_lt_b_s ^ max_i) begin
         result_o = a_i;
      end else begin
         result_o = b_i;
      end
   end

endmodule

// File: rtl/fpu_misc_pipe.sv
// Two-stage FP misc unit (FMIN/FMAX/FSGNJ*): S1 holds operands, S2 holds the
// registered result; valid/ready in, valid/yumi out, flush kills both stages.
module fpu_misc_pipe
   import fpu_misc_pipe_pkg::*;
#(
   parameter  int exp_width_p = 8,
   parameter  int sig_width_p = 24,
   parameter  int tag_width_p = 5,
   localparam int recoded_data_width_lp = exp_width_p + sig_width_p + 1
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             flush_i,
   input  logic                             v_i,
   output logic                             ready_o,
   input  fpu_misc_op_e                     op_i,
   input  logic [recoded_data_width_lp-1:0] fp_rs1_i,
   input  logic [recoded_data_width_lp-1:0] fp_rs2_i,
   input  logic [tag_width_p-1:0]           tag_i,
   output logic                             v_o,
   input  logic                             yumi_i,
   output logic [recoded_data_width_lp-1:0] result_o,
   output logic [4:0]                       fflags_o,
   output logic [tag_width_p-1:0]           tag_o
);

   localparam int rd_lp = recoded_data_width_lp;

   logic                   s1_v_r;
   fpu_misc_op_e           s1_op_r;
   logic [rd_lp-1:0]       s1_rs1_r;
   logic [rd_lp-1:0]       s1_rs2_r;
   logic [tag_width_p-1:0] s1_tag_r;
   logic                   s2_v_r;
   logic [rd_lp-1:0]       s2_result_r;
   fpu_fflags_s            s2_fflags_r;
   logic [tag_width_p-1:0] s2_tag_r;

   logic                   s2_adv_s;
   logic                   s1_mv_s;
   logic                   accept_s;
   logic [rd_lp-1:0]       mm_result_s;
   logic                   mm_nv_s;
   logic [rd_lp-1:0]       res_s;
   fpu_fflags_s            flags_s;

   // yumi_i reaches ready_o combinationally on purpose: no skid buffer here
   assign s2_adv_s = ~s2_v_r | yumi_i;
   assign s1_mv_s  = s1_v_r & s2_adv_s;
   assign ready_o  = ~flush_i & (~s1_v_r | s2_adv_s);
   assign accept_s = v_i & ready_o;

   assign v_o      = s2_v_r;
   assign result_o = s2_result_r;
   assign fflags_o = s2_fflags_r;
   assign tag_o    = s2_tag_r;

   fpu_misc_pipe_fmin_fmax #(
      .exp_width_p(exp_width_p),
      .sig_width_p(sig_width_p)
   ) fmin_fmax (
      .a_i     (s1_rs1_r),
      .b_i     (s1_rs2_r),
      .max_i   (s1_op_r == eFMAX),
      .result_o(mm_result_s),
      .nv_o    (mm_nv_s)
   );

   // Result and flags computed from the S1 registers
   always_comb begin
      res_s   = s1_rs1_r;
      flags_s = '0;
      case (s1_op_r)
         eFMIN, eFMAX: begin
            res_s      = mm_result_s;
            flags_s.nv = mm_nv_s;
         end
         eFSGNJ:  res_s = {s1_rs2_r[rd_lp-1], s1_rs1_r[rd_lp-2:0]};
         eFSGNJN: res_s = {~s1_rs2_r[rd_lp-1], s1_rs1_r[rd_lp-2:0]};
         eFSGNJX: res_s = {s1_rs1_r[rd_lp-1] ^ s1_rs2_r[rd_lp-1], s1_rs1_r[rd_lp-2:0]};
         default: begin
            res_s   = s1_rs1_r;
            flags_s = '0;
         end
      endcase
   end

   // Stage valid bits; flush wins over everything except reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_v_r <= 1'b0;
         s2_v_r <= 1'b0;
      end else if (flush_i) begin
         s1_v_r <= 1'b0;
         s2_v_r <= 1'b0;
      end else begin
         s1_v_r <= accept_s | (s1_v_r & ~s2_adv_s);
         s2_v_r <= s2_adv_s ? s1_v_r : s2_v_r;
      end
   end

   // S1 operand capture on accept
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_op_r  <= eFMIN;
         s1_rs1_r <= '0;
         s1_rs2_r <= '0;
         s1_tag_r <= '0;
      end else if (accept_s) begin
         s1_op_r  <= op_i;
         s1_rs1_r <= fp_rs1_i;
         s1_rs2_r <= fp_rs2_i;
         s1_tag_r <= tag_i;
      end
   end

   // S2 result capture when S1 moves forward
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s2_result_r <= '0;
         s2_fflags_r <= '0;
         s2_tag_r    <= '0;
      end else if (s1_mv_s) begin
         s2_result_r <= res_s;
         s2_fflags_r <= flags_s;
         s2_tag_r    <= s1_tag_r;
      end
   end

endmodule

// File: tb/tb_fpu_misc_pipe.sv
// Scoreboard bench for fpu_misc_pipe: randomized and directed ops checked
// against a value-level reference model of FMIN/FMAX/sign injection.
module tb_fpu_misc_pipe;
   import fpu_misc_pipe_pkg::*;

   logic         clk;
   logic         reset_n_i;
   logic         flush_i;
   logic         v_i;
   logic         ready_o;
   fpu_misc_op_e op_i;
   logic [32:0]  fp_rs1_i;
   logic [32:0]  fp_rs2_i;
   logic [4:0]   tag_i;
   logic         v_o;
   logic         yumi_i;
   logic [32:0]  result_o;
   logic [4:0]   fflags_o;
   logic [4:0]   tag_o;

   fpu_misc_pipe dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i),
      .ready_o(ready_o), .op_i(op_i), .fp_rs1_i(fp_rs1_i), .fp_rs2_i(fp_rs2_i),
      .tag_i(tag_i), .v_o(v_o), .yumi_i(yumi_i), .result_o(result_o),
      .fflags_o(fflags_o), .tag_o(tag_o)
   );

   localparam logic [32:0] ONE  = 33'h0_8000_0000;
   localparam logic [32:0] TWO  = 33'h0_8080_0000;
   localparam logic [32:0] MONE = 33'h1_8000_0000;
   localparam logic [32:0] PZ   = 33'h0_0000_0000;
   localparam logic [32:0] NZ   = 33'h1_0000_0000;
   localparam logic [32:0] QNAN = 33'h0_E040_0000;
   localparam logic [32:0] SNAN = 33'h0_E000_0001;

   typedef struct {
      logic [32:0] res;
      logic [4:0]  fl;
      logic [4:0]  tag;
      bit          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mode = 0;      // 0: always consume, 1: random, 2: never
   bit          lat_chk = 0;
   bit          flush_last = 0;
   bit          held = 0;
   logic [32:0] h_res;
   logic [4:0]  h_fl;
   logic [4:0]  h_tag;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic bit is_nan(input logic [32:0] x);
      return x[31:29] == 3'b111;
   endfunction

   function automatic real val(input logic [32:0] x);
      real m;
      int  e;
      e = int'(x[31:23]);
      if (x[31:29] == 3'b000) m = 0.0;
      else if (x[31:29] == 3'b110) m = 1.0e300;
      else m = (2.0 ** (e - 256)) * (1.0 + real'(x[22:0]) / 8388608.0);
      return x[32] ? -m : m;
   endfunction

   // reference: RISC-V min/max on real values, sign injection on fields
   task automatic model(input int op, input logic [32:0] a, input logic [32:0] b,
                        output logic [32:0] r, output logic [4:0] f);
      bit less;
      f = 5'h00;
      r = a;
      if (op == 0 || op == 1) begin
         if ((is_nan(a) && !a[22]) || (is_nan(b) && !b[22])) f = 5'h10;
         if (is_nan(a) && is_nan(b)) r = QNAN;
         else if (is_nan(a)) r = b;
         else if (is_nan(b)) r = a;
         else begin
            less = (val(a) < val(b)) || (val(a) == val(b) && a[32] && !b[32]);
            if (op == 0) r = less ? a : b;
            else r = less ? b : a;
         end
      end else if (op == 2) r = {b[32], a[31:0]};
      else if (op == 3) r = {~b[32], a[31:0]};
      else if (op == 4) r = {a[32] ^ b[32], a[31:0]};
   endtask

   function automatic logic [32:0] rnd_val();
      logic s;
      logic [8:0] e;
      s = 1'($urandom_range(0, 1));
      e = 9'($urandom_range(130, 383));
      case ($urandom_range(0, 5))
         0:       return {s, 32'h0};
         3:       return {s, 9'h180, 23'h0};
         4:       return {s, 3'b111, 6'($urandom), 1'b1, 22'($urandom)};
         5:       return {s, 3'b111, 6'($urandom), 1'b0, 22'($urandom) | 22'h1};
         default: return {s, e, 23'($urandom)};
      endcase
   endfunction

   // Monitor: pops and compares on every consumed result, checks hold stability
   always @(negedge clk) begin
      exp_t e;
      bit   take;
      if (!reset_n_i) begin
         held   = 0;
         yumi_i = 1'b0;
      end else begin
         if (held && !flush_last) begin
            chk("hold_v", 64'(v_o), 64'd1);
            chk("hold_res", 64'(result_o), 64'(h_res));
            chk("hold_tag", 64'({h_fl, tag_o}), 64'({fflags_o, h_tag}));
         end
         if (v_o) begin
            if (q.size() == 0) chk("unexpected_v_o", 64'(v_o), 64'd0);
            take = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (take && q.size() > 0) begin
               e = q.pop_front();
               chk("result", 64'(result_o), 64'(e.res));
               chk("fflags", 64'(fflags_o), 64'(e.fl));
               chk("tag", 64'(tag_o), 64'(e.tag));
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd1);
            end
            yumi_i = take;
            held   = !take;
            h_res  = result_o;
            h_fl   = fflags_o;
            h_tag  = tag_o;
         end else begin
            yumi_i = 1'b0;
            held   = 0;
         end
      end
   end

   // One cycle of input drive; expected result queued when the op is accepted
   task automatic drive(input int op, input logic [32:0] a, input logic [32:0] b,
                        input logic [4:0] t, input bit v, input bit fl, output bit acc);
      exp_t e;
      @(negedge clk);
      #2;
      v_i = v; op_i = fpu_misc_op_e'(op[2:0]); fp_rs1_i = a; fp_rs2_i = b;
      tag_i = t; flush_i = fl;
      #2;
      acc = v && ready_o;
      if (fl) begin
         chk("flush_ready", 64'(ready_o), 64'd0);
         q.delete();
      end
      if (acc) begin
         model(op, a, b, e.res, e.fl);
         e.tag = t; e.lat = lat_chk; e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      v_i = 1'b0; flush_i = 1'b0; flush_last = fl;
   endtask

   task automatic send(input int op, input logic [32:0] a, input logic [32:0] b, input logic [4:0] t);
      bit acc;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) drive(op, a, b, t, 1'b1, 1'b0, acc);
      chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      mode = 0;
      for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          k;
      logic [32:0] a, b;
      logic [32:0] bpa[4];
      reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
      op_i = eFMIN; fp_rs1_i = '0; fp_rs2_i = '0; tag_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_v_o", 64'(v_o), 64'd0);
      chk("rst_result", 64'(result_o), 64'd0);
      chk("rst_fflags_tag", 64'({fflags_o, tag_o}), 64'd0);
      #2 reset_n_i = 1'b1;
      #1 chk("rst_ready", 64'(ready_o), 64'd1);

      // directed values, yumi tied high
      mode = 0; lat_chk = 1;
      send(0, ONE, TWO, 5'd3);
      send(1, NZ, PZ, 5'd4);
      send(1, SNAN, TWO, 5'd5);
      send(0, QNAN, QNAN, 5'd6);
      send(3, ONE, ONE, 5'd7);
      send(4, MONE, MONE, 5'd8);
      send(2, SNAN, MONE, 5'd9);
      send(0, MONE, NZ, 5'd10);
      send(5, TWO, ONE, 5'd11);
      send(7, MONE, ONE, 5'd12);
      drain();

      // backpressure: two accepts then stall, then in-order drain
      lat_chk = 0; mode = 2; k = 0;
      bpa[0] = ONE; bpa[1] = TWO; bpa[2] = MONE; bpa[3] = NZ;
      for (int c = 0; c < 4; c++) begin
         drive(k % 2, bpa[k], TWO, 5'(20 + k), 1'b1, 1'b0, acc);
         chk("bp_accept", 64'(acc), (c < 2) ? 64'd1 : 64'd0);
         if (acc) k++;
      end
      chk("bp_count", 64'(k), 64'd2);
      mode = 0;
      while (k < 4) begin
         send(k % 2, bpa[k], TWO, 5'(20 + k));
         k++;
      end
      drain();

      // flush with both stages full and a pending input
      mode = 2;
      send(1, ONE, TWO, 5'd1);
      send(0, ONE, TWO, 5'd2);
      drive(0, TWO, ONE, 5'd3, 1'b1, 1'b1, acc);
      chk("flush_accept", 64'(acc), 64'd0);
      @(negedge clk);
      #1 chk("flush_v_o", 64'(v_o), 64'd0);
      mode = 0; lat_chk = 1;
      send(1, MONE, ONE, 5'd17);
      drain();

      // asynchronous reset mid-stream
      lat_chk = 0; mode = 2;
      send(2, ONE, MONE, 5'd1);
      send(3, TWO, MONE, 5'd2);
      @(negedge clk);
      #3 reset_n_i = 1'b0;
      #1;
      chk("async_rst_v_o", 64'(v_o), 64'd0);
      chk("async_rst_result", 64'(result_o), 64'd0);
      chk("async_rst_ready", 64'(ready_o), 64'd1);
      q.delete();
      repeat (2) @(negedge clk);
      #3 reset_n_i = 1'b1;
      mode = 0;
      repeat (5) @(negedge clk);
      #1 chk("post_rst_v_o", 64'(v_o), 64'd0);

      // randomized traffic with random consumption and occasional flush
      mode = 1;
      for (int i = 0; i < 400; i++) begin
         a = rnd_val();
         case ($urandom_range(0, 4))
            0:       b = a;
            1:       b = {~a[32], a[31:0]};
            default: b = rnd_val();
         endcase
         drive(($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 4), a, b,
               5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, acc);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_misc_pipe.md
Name: fpu_misc_pipe

Overview:
Two-stage pipelined FPU "misc" unit for the vanilla core's FP path. It takes recoded operands from FP issue and performs FMIN, FMAX, FSGNJ, FSGNJN and FSGNJX. It returns a registered recoded result plus exception flags to FP writeback. Input side is a valid/ready handshake; output side is a valid/yumi handshake. A flush kills all in-flight operations.

Parameters:
exp_width_p, 8, recoded exponent width minus one (IEEE exponent width).
sig_width_p, 24, significand width including hidden bit.
tag_width_p, 5, width of the destination-register tag carried alongside the op.
(localparam recoded_data_width_lp = exp_width_p+sig_width_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous, active-low
flush_i  in  1  kill all in-flight ops
v_i  in  1  input op valid
ready_o  out  1  unit can accept an op this cycle
op_i  in  fpu_misc_op_e  operation select
fp_rs1_i  in  recoded_data_width_lp  recoded operand 1
fp_rs2_i  in  recoded_data_width_lp  recoded operand 2
tag_i  in  tag_width_p  destination tag
v_o  out  1  result valid
yumi_i  in  1  downstream consumes result; legal only when v_o=1
result_o  out  recoded_data_width_lp  recoded result
fflags_o  out  5  {NV,DZ,OF,UF,NX}
tag_o  out  tag_width_p  tag of the result

Behaviour:
- One clock, clk_i. reset_n_i is asynchronous and active-low. All state is reset asynchronously while reset_n_i=0.
- Reset values: stage-1 and stage-2 valid bits = 0, all data registers = 0. Therefore v_o=0, result_o=0, fflags_o=0, tag_o=0. After reset deassertion, ready_o=1 unless flush_i=1.
- Stage 1 (S1) registers op, rs1, rs2 and tag. Stage 2 (S2) registers result, fflags and tag.
- Accept: an op is accepted when v_i & ready_o at a rising edge.
- S2 advance: s2_adv = ~s2_v | yumi_i.
- S1 move into S2: s1_v & s2_adv.
- ready_o = ~flush_i & (~s1_v | s2_adv). This is a combinational path from yumi_i to ready_o and is intentional; there is no skid buffer.
- Latency: an op accepted at edge k is in S1 after k and in S2 after k+1. v_o is high in the cycle after k+1.
- Throughput: 1 op/cycle while yumi_i is held high.
- Backpressure: while v_o=1 and yumi_i=0, S2 holds result_o, fflags_o and tag_o stable. S1 also holds if it is valid.
- Bubble collapse: if S2 is empty or being consumed, S1 advances regardless of the input.
- flush_i=1 at an edge:
  - clears s1_v and s2_v;
  - forces ready_o=0, so no op is accepted that cycle;
  - a yumi_i asserted in the same cycle is still honoured (result consumed, then cleared).
  - Data registers are not cleared.
- The S1→S2 combinational compute operates on S1 registers:
  - FMIN/FMAX: RISC-V semantics.
    - -0.0 < +0.0.
    - Both NaN → canonical NaN (`FPU_RECODED_CANONICAL_NAN).
    - One NaN → the other operand.
    - NV = 1 if either operand is a signalling NaN.
  - NaN detect on recoded data: the top 3 exponent bits are all 1. A NaN is signalling when significand bit sig_width_p-2 is 0.
  - FSGNJ: {rs2.sign, rs1[recoded_data_width_lp-2:0]}.
  - FSGNJN: {~rs2.sign, rs1 rest}.
  - FSGNJX: {rs1.sign^rs2.sign, rs1 rest}.
  - Sign-injection ops never set flags and pass NaN payloads unchanged.
  - Undefined op encodings: result = rs1, fflags = 0. This must not hang the pipe.
- fflags_o bits DZ/OF/UF/NX are always 0.
- Behaviour is undefined if yumi_i=1 while v_o=0; the bench asserts against this.

Decomposition:
- Shared package (bsg_vanilla_pkg): typedef enum logic [2:0] fpu_misc_op_e with eFMIN=0, eFMAX=1, eFSGNJ=2, eFSGNJN=3, eFSGNJX=4.
- Shared package: typedef struct fpu_fflags_s {nv,dz,of,uf,nx}.
- The canonical-NaN macro stays in the shared instruction defines.
- Sub-module: reuse the existing fpu_fmin_fmax combinational block for FMIN/FMAX. Sign injection and the pipeline control are local.

Test Plan:
(Values are 33-bit recoded, exp 8 / sig 24. 1.0=0x080000000, 2.0=0x080800000, -1.0=0x180000000, +0=0x000000000, -0=0x100000000, qNaN=0x0E0400000, sNaN=0x0E0000001.)
- Reset: hold reset_n_i=0 mid-stream with S1 and S2 full → v_o=0 immediately (asynchronous). After release, ready_o=1 and no stale output appears.
- FMIN(1.0, 2.0), tag 3, yumi_i tied 1 → v_o high 2 edges after accept; result 0x080000000, fflags 0, tag_o 3. FMAX(-0, +0) → 0x000000000.
- FMAX(sNaN, 2.0) → 0x080800000 with fflags=0x10. FMIN(qNaN, qNaN) → 0x0E0400000 with fflags=0.
- Sign injection: FSGNJN(1.0, 1.0) → 0x180000000; FSGNJX(-1.0, -1.0) → 0x080000000; FSGNJ(sNaN, -1.0) → 0x1E0000001 with fflags=0.
- Backpressure: issue 4 back-to-back ops with yumi_i=0 → ready_o drops after 2 accepts and outputs stay stable. Raising yumi_i then drains all 4 in order at 1 per cycle with no loss or duplication.
- Flush with S1 and S2 full and v_i=1 → that cycle ready_o=0; next cycle v_o=0, and the next accepted op emerges correctly 2 edges later.
